udp_echo_responder: RTL and testbench
=====================================

# udp_echo_responder

Packet-accurate UDP echo stage that sits between the `udp_complete` UDP output (`m_udp_*`) and UDP input (`s_udp_*`) inside the loopback server. It replaces the bare payload FIFO and header cross-wiring there.

- Buffers each received payload.
- Commits it only when it ends cleanly.
- Then issues a reply header (swapped ports, reversed IP) followed by the stored payload.
- Errored, oversize or filtered packets are discarded by rewinding the write pointer.

## Interface
Parameters:
- `DATA_WIDTH`, 8, payload beat width; only 8 is supported.
- `MAX_PAYLOAD_BYTES`, 1472, largest payload accepted.
- `BUF_DEPTH`, 2048, payload RAM bytes. Power of two, ≥ `MAX_PAYLOAD_BYTES`.
- `HDR_QUEUE_DEPTH`, 4, committed-packet header slots. Power of two.
- `PORT_FILTER_ENABLE`, 0, when 1 only `LISTEN_PORT` is echoed.
- `LISTEN_PORT`, 16'd5000, accepted destination port when filtering.

Ports:
- `sys_clk`  in  1  single clock for all logic.
- `system_reset`  in  1  synchronous, active-low reset (0 = reset).
- `rx_hdr_valid` / `rx_hdr_ready`  in/out  1  received UDP header handshake.
- `rx_ip_source_ip`  in  32  sender IP.
- `rx_source_port`, `rx_dest_port`, `rx_length`  in  16  received UDP header fields.
- `rx_payload`  axis_interface.Sink  8  received payload (tdata/tvalid/tready/tlast/tuser).
- `tx_hdr_valid` / `tx_hdr_ready`  out/in  1  reply header handshake.
- `tx_ip_dest_ip`  out  32  reply destination IP.
- `tx_source_port`, `tx_dest_port`, `tx_length`  out  16  reply UDP header fields.
- `tx_payload`  axis_interface.Source  8  reply payload; tuser is always 0.
- `drop_count`  out  16  saturating count of error/oversize drops.
- `busy`  out  1  high when either FSM is not idle or the header queue is non-empty.

## Operation
RX FSM, states `RX_IDLE`, `RX_PAYLOAD`, `RX_DROP`, `RX_FILTER`:
- **Header accept.** `rx_hdr_ready` = (state == `RX_IDLE`) && header queue not full && free bytes ≥ `MAX_PAYLOAD_BYTES`. On handshake, latch the header fields and zero the byte counter.
- **Zero-length packets.** If `rx_length` ≤ 8, stay in `RX_IDLE`, increment `drop_count` and consume no payload.
- **Port filter.** If the filter is enabled and `rx_dest_port` != `LISTEN_PORT`, go to `RX_FILTER`.
- **Otherwise** go to `RX_PAYLOAD`.
- **`RX_PAYLOAD`.** `rx_payload.tready` = 1. Each beat writes `ram[wr_ptr]`, increments `wr_ptr` and the count.
  - Count reaching `MAX_PAYLOAD_BYTES` without tlast: go to `RX_DROP`.
  - tlast with tuser = 0: commit. Set `commit_ptr` ← `wr_ptr` + 1, push the queue entry {source_ip, rx_dest_port, rx_source_port, count + 1}, return to `RX_IDLE`.
  - tlast with tuser = 1: set `wr_ptr` ← `commit_ptr`, increment `drop_count`, return to `RX_IDLE`.
- **`RX_DROP` / `RX_FILTER`.** tready = 1, data discarded. On tlast: set `wr_ptr` ← `commit_ptr` and go to `RX_IDLE`. `RX_DROP` increments `drop_count`; `RX_FILTER` does not.
- **Pointer arithmetic.** Pointers are log2(`BUF_DEPTH`)+1 bits and wrap naturally. Free bytes = `BUF_DEPTH` − (`wr_ptr` − `rd_ptr`).

TX FSM, states `TX_IDLE`, `TX_HDR`, `TX_PAYLOAD`:
- **`TX_IDLE`.** When the queue is non-empty, load the head entry into the output registers and go to `TX_HDR`.
- **`TX_HDR`.** `tx_hdr_valid` = 1 with fields stable until `tx_hdr_ready`. `tx_length` = count + 8. On handshake, pop the queue and go to `TX_PAYLOAD`.
- **`TX_PAYLOAD`.** Read `ram[rd_ptr]` through a one-entry output register (prefetch plus hold). tdata/tvalid stay stable while tready = 0. tlast is asserted on beat number count. After the tlast handshake, go to `TX_IDLE`.
- **Concurrency.** RX commit and TX read of different regions in the same cycle are legal. A queue push and pop in the same cycle leaves occupancy unchanged.
- **Counter saturation.** `drop_count` saturates at 0xFFFF.

## Timing
- **Reset values.** Every valid, ready and tlast is 0. `drop_count`, pointers and the queue are 0. `busy` is 0. Both FSMs are idle. A reset mid-packet abandons all buffered data.
- **Accept rate.** `rx_hdr_ready` is high one cycle after reset release when idle. Payload is accepted at 1 byte/cycle starting the cycle after the header handshake.
- **Commit to reply header.** A commit on the tlast beat at cycle T gives `tx_hdr_valid` at T+2 at the earliest.
- **Reply header to payload.** `tx_payload.tvalid` is asserted 2 cycles after the header handshake (RAM read + register), then sustains 1 byte/cycle while tready = 1.
- **Drop counter.** `drop_count` updates the cycle after the drop event.

## Structure
- **`udp_echo_pkg`** holds:
  - `rx_state_t` and `tx_state_t` enums;
  - `udp_reply_hdr_t` packed struct {ip 32, src_port 16, dst_port 16, count 16};
  - `localparam UDP_HDR_BYTES = 8`.
- **Sub-module `udp_echo_payload_ram`.** Simple dual-port RAM, one write port and one registered read port, `BUF_DEPTH` × 8.
- **Header queue.** A small register-array FIFO inside the top module.

## Test plan
- **Basic echo.** Header {10.0.0.2, 1234→5000, len 12} with payload DE AD BE EF → tx header {10.0.0.2, src 5000, dst 1234, len 12}, payload DE AD BE EF with tlast on beat 4, `drop_count` 0.
- **Error rewind.** 6-byte packet with tuser = 1 on tlast → no tx header, `drop_count` = 1. The next 3-byte packet 01 02 03 echoes exactly (pointer rewind verified).
- **Oversize.** Payload of `MAX_PAYLOAD_BYTES`+1 bytes → no reply, `drop_count` = 1, `rx_hdr_ready` high again after tlast.
- **Back-pressure.** `tx_hdr_ready` held 0 while 5 two-byte packets arrive → `rx_hdr_ready` drops after 4 headers. Releasing it yields all 5 replies in order with correct bytes.
- **Port filter.** `PORT_FILTER_ENABLE` = 1, dest port 5001 → payload consumed, no reply, `drop_count` unchanged. Port 5000 is echoed.
- **Reset mid-operation.** `system_reset` = 0 mid-payload and mid-tx → all outputs at reset values next cycle. After release, a fresh 4-byte packet echoes correctly.

Source files
------------

// File: rtl/udp_echo_pkg.sv
// rtl/udp_echo_pkg.sv - shared types and constants for the UDP echo responder
package udp_echo_pkg;

   localparam int UDP_HDR_BYTES = 8;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_PAYLOAD,
      RX_DROP,
      RX_FILTER
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_HDR,
      TX_PAYLOAD
   } tx_state_t;

   typedef struct packed {
      logic [31:0] ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] count;
   } udp_reply_hdr_t;

endpackage

// File: rtl/udp_echo_payload_ram.sv
// rtl/udp_echo_payload_ram.sv - simple dual-port payload RAM with registered read
module udp_echo_payload_ram #(
   parameter int DEPTH = 2048,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // rdata holds its value when re is low; the TX pipeline relies on that as a stage
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/udp_echo_responder.sv
// rtl/udp_echo_responder.sv - buffers, commits and echoes UDP payloads with swapped header
module udp_echo_responder
   import udp_echo_pkg::*;
#(
   parameter int          DATA_WIDTH         = 8,
   parameter int          MAX_PAYLOAD_BYTES  = 1472,
   parameter int          BUF_DEPTH          = 2048,
   parameter int          HDR_QUEUE_DEPTH    = 4,
   parameter int          PORT_FILTER_ENABLE = 0,
   parameter logic [15:0] LISTEN_PORT        = 16'd5000
) (
   input  logic                  sys_clk,
   input  logic                  system_reset,
   input  logic                  rx_hdr_valid,
   output logic                  rx_hdr_ready,
   input  logic [31:0]           rx_ip_source_ip,
   input  logic [15:0]           rx_source_port,
   input  logic [15:0]           rx_dest_port,
   input  logic [15:0]           rx_length,
   input  logic [DATA_WIDTH-1:0] rx_payload_tdata,
   input  logic                  rx_payload_tvalid,
   output logic                  rx_payload_tready,
   input  logic                  rx_payload_tlast,
   input  logic                  rx_payload_tuser,
   output logic                  tx_hdr_valid,
   input  logic                  tx_hdr_ready,
   output logic [31:0]           tx_ip_dest_ip,
   output logic [15:0]           tx_source_port,
   output logic [15:0]           tx_dest_port,
   output logic [15:0]           tx_length,
   output logic [DATA_WIDTH-1:0] tx_payload_tdata,
   output logic                  tx_payload_tvalid,
   input  logic                  tx_payload_tready,
   output logic                  tx_payload_tlast,
   output logic                  tx_payload_tuser,
   output logic [15:0]           drop_count,
   output logic                  busy
);

   localparam int AW  = $clog2(BUF_DEPTH);
   localparam int PW  = AW + 1;
   localparam int QAW = $clog2(HDR_QUEUE_DEPTH);
   localparam int QW  = QAW + 1;
   localparam logic [PW-1:0] USED_LIMIT = PW'(BUF_DEPTH - MAX_PAYLOAD_BYTES);
   localparam logic [15:0]   MAX_CNT    = 16'(MAX_PAYLOAD_BYTES);
   localparam logic [QW-1:0] Q_FULL_CNT = QW'(HDR_QUEUE_DEPTH);

   rx_state_t rx_state_q, rx_state_d;
   tx_state_t tx_state_q, tx_state_d;
   logic run_q;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [15:0] rx_count_q, rx_count_d, drop_q, drop_d, issued_q, issued_d;
   logic [31:0] src_ip_q, src_ip_d;
   logic [15:0] src_port_q, src_port_d, dst_port_q, dst_port_d;
   udp_reply_hdr_t q_mem [HDR_QUEUE_DEPTH];
   udp_reply_hdr_t q_push_entry, hdr_q, hdr_d;
   logic [QW-1:0] q_wp_q, q_rp_q;
   logic q_push, q_pop, q_empty, q_full, drop_inc;
   logic ram_we, ram_re, out_free, issue;
   logic [DATA_WIDTH-1:0] ram_rdata, out_data_q, out_data_d;
   logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d;

   assign q_empty = (q_wp_q == q_rp_q);
   assign q_full  = ((q_wp_q - q_rp_q) == Q_FULL_CNT);
   // run_q keeps the header port closed while reset is held
   assign rx_hdr_ready = run_q && (rx_state_q == RX_IDLE) && !q_full &&
                         ((wr_ptr_q - rd_ptr_q) <= USED_LIMIT);
   assign rx_payload_tready = (rx_state_q != RX_IDLE);

   always_comb begin
      rx_state_d   = rx_state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rx_count_d   = rx_count_q;
      src_ip_d     = src_ip_q;
      src_port_d   = src_port_q;
      dst_port_d   = dst_port_q;
      ram_we       = 1'b0;
      q_push       = 1'b0;
      drop_inc     = 1'b0;
      q_push_entry = '{ip: src_ip_q, src_port: dst_port_q, dst_port: src_port_q,
                       count: rx_count_q + 16'd1};
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_hdr_valid && rx_hdr_ready) begin
               src_ip_d   = rx_ip_source_ip;
               src_port_d = rx_source_port;
               dst_port_d = rx_dest_port;
               rx_count_d = '0;
               if (rx_length <= 16'(UDP_HDR_BYTES)) begin
                  drop_inc = 1'b1;
               end else if ((PORT_FILTER_ENABLE != 0) && (rx_dest_port != LISTEN_PORT)) begin
                  rx_state_d = RX_FILTER;
               end else begin
                  rx_state_d = RX_PAYLOAD;
               end
            end
         end
         RX_PAYLOAD: begin
            if (rx_payload_tvalid) begin
               ram_we     = 1'b1;
               wr_ptr_d   = wr_ptr_q + 1'b1;
               rx_count_d = rx_count_q + 16'd1;
               if (rx_payload_tlast && !rx_payload_tuser) begin
                  commit_ptr_d = wr_ptr_q + 1'b1;
                  q_push       = 1'b1;
                  rx_state_d   = RX_IDLE;
               end else if (rx_payload_tlast) begin
                  wr_ptr_d   = commit_ptr_q;
                  drop_inc   = 1'b1;
                  rx_state_d = RX_IDLE;
               end else if (rx_count_q + 16'd1 == MAX_CNT) begin
                  rx_state_d = RX_DROP;
               end
            end
         end
         default: begin
            if (rx_payload_tvalid && rx_payload_tlast) begin
               wr_ptr_d   = commit_ptr_q;
               drop_inc   = (rx_state_q == RX_DROP);
               rx_state_d = RX_IDLE;
            end
         end
      endcase
      drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   end

   // Two-stage read pipeline: RAM output register, then the stream output register
   always_comb begin
      tx_state_d  = tx_state_q;
      hdr_d       = hdr_q;
      issued_d    = issued_q;
      rd_ptr_d    = rd_ptr_q;
      q_pop       = 1'b0;
      ram_re      = 1'b0;
      rd_valid_d  = rd_valid_q;
      rd_last_d   = rd_last_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_free    = !out_valid_q || tx_payload_tready;
      if (out_free) begin
         out_valid_d = rd_valid_q;
         out_last_d  = rd_valid_q && rd_last_q;
         if (rd_valid_q) begin
            out_data_d = ram_rdata;
         end
         rd_valid_d = 1'b0;
      end
      case (tx_state_q)
         TX_IDLE: begin
            if (!q_empty) begin
               hdr_d      = q_mem[q_rp_q[QAW-1:0]];
               issued_d   = '0;
               tx_state_d = TX_HDR;
            end
         end
         TX_HDR: begin
            if (tx_hdr_ready) begin
               q_pop      = 1'b1;
               tx_state_d = TX_PAYLOAD;
            end
         end
         TX_PAYLOAD: begin
            if (out_valid_q && tx_payload_tready && out_last_q) begin
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      issue = (!rd_valid_q || out_free) &&
              (((tx_state_q == TX_HDR) && tx_hdr_ready) ||
               ((tx_state_q == TX_PAYLOAD) && (issued_q != hdr_q.count)));
      if (issue) begin
         ram_re     = 1'b1;
         rd_ptr_d   = rd_ptr_q + 1'b1;
         issued_d   = issued_q + 16'd1;
         rd_valid_d = 1'b1;
         rd_last_d  = (issued_q + 16'd1 == hdr_q.count);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (q_push) begin
         q_mem[q_wp_q[QAW-1:0]] <= q_push_entry;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!system_reset) begin
         rx_state_q   <= RX_IDLE;
         tx_state_q   <= TX_IDLE;
         run_q        <= 1'b0;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         rx_count_q   <= '0;
         drop_q       <= '0;
         issued_q     <= '0;
         src_ip_q     <= '0;
         src_port_q   <= '0;
         dst_port_q   <= '0;
         q_wp_q       <= '0;
         q_rp_q       <= '0;
         hdr_q        <= '0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         tx_state_q   <= tx_state_d;
         run_q        <= 1'b1;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rx_count_q   <= rx_count_d;
         drop_q       <= drop_d;
         issued_q     <= issued_d;
         src_ip_q     <= src_ip_d;
         src_port_q   <= src_port_d;
         dst_port_q   <= dst_port_d;
         q_wp_q       <= q_wp_q + QW'(q_push);
         q_rp_q       <= q_rp_q + QW'(q_pop);
         hdr_q        <= hdr_d;
         rd_valid_q   <= rd_valid_d;
         rd_last_q    <= rd_last_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
      end
   end

   udp_echo_payload_ram #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (sys_clk),
      .we    (ram_we),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (rx_payload_tdata),
      .re    (ram_re),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (ram_rdata)
   );

   assign tx_hdr_valid      = (tx_state_q == TX_HDR);
   assign tx_ip_dest_ip     = hdr_q.ip;
   assign tx_source_port    = hdr_q.src_port;
   assign tx_dest_port      = hdr_q.dst_port;
   assign tx_length         = hdr_q.count + 16'(UDP_HDR_BYTES);
   assign tx_payload_tdata  = out_data_q;
   assign tx_payload_tvalid = out_valid_q;
   assign tx_payload_tlast  = out_last_q;
   assign tx_payload_tuser  = 1'b0;
   assign drop_count        = drop_q;
   assign busy = (rx_state_q != RX_IDLE) || (tx_state_q != TX_IDLE) || !q_empty;

endmodule

// File: tb/tb_udp_echo_responder.sv
// tb/tb_udp_echo_responder.sv - directed self-checking bench for udp_echo_responder
module tb_udp_echo_responder;

   logic        sys_clk = 1'b0;
   logic        system_reset;
   logic        rx_hdr_valid;
   logic        rx_hdr_ready;
   logic [31:0] rx_ip_source_ip;
   logic [15:0] rx_source_port, rx_dest_port, rx_length;
   logic [7:0]  rx_payload_tdata;
   logic        rx_payload_tvalid, rx_payload_tready, rx_payload_tlast, rx_payload_tuser;
   logic        tx_hdr_valid;
   logic        tx_hdr_ready;
   logic [31:0] tx_ip_dest_ip;
   logic [15:0] tx_source_port, tx_dest_port, tx_length;
   logic [7:0]  tx_payload_tdata;
   logic        tx_payload_tvalid;
   logic        tx_payload_tready = 1'b1;
   logic        tx_payload_tlast, tx_payload_tuser;
   logic [15:0] drop_count;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int hdr_cyc  = 0;
   bit first_pending = 0;
   bit stall_pending = 0;
   logic [7:0] stall_data;
   logic       stall_last;
   bit tready_mode = 0;

   logic [7:0]  pl[$];
   logic [79:0] got_hdr[$];
   logic [8:0]  got_beat[$];
   int          got_lat[$];

   udp_echo_responder #(
      .PORT_FILTER_ENABLE (1),
      .LISTEN_PORT        (16'd5000)
   ) dut (
      .sys_clk           (sys_clk),
      .system_reset      (system_reset),
      .rx_hdr_valid      (rx_hdr_valid),
      .rx_hdr_ready      (rx_hdr_ready),
      .rx_ip_source_ip   (rx_ip_source_ip),
      .rx_source_port    (rx_source_port),
      .rx_dest_port      (rx_dest_port),
      .rx_length         (rx_length),
      .rx_payload_tdata  (rx_payload_tdata),
      .rx_payload_tvalid (rx_payload_tvalid),
      .rx_payload_tready (rx_payload_tready),
      .rx_payload_tlast  (rx_payload_tlast),
      .rx_payload_tuser  (rx_payload_tuser),
      .tx_hdr_valid      (tx_hdr_valid),
      .tx_hdr_ready      (tx_hdr_ready),
      .tx_ip_dest_ip     (tx_ip_dest_ip),
      .tx_source_port    (tx_source_port),
      .tx_dest_port      (tx_dest_port),
      .tx_length         (tx_length),
      .tx_payload_tdata  (tx_payload_tdata),
      .tx_payload_tvalid (tx_payload_tvalid),
      .tx_payload_tready (tx_payload_tready),
      .tx_payload_tlast  (tx_payload_tlast),
      .tx_payload_tuser  (tx_payload_tuser),
      .drop_count        (drop_count),
      .busy              (busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   always @(posedge sys_clk) begin
      #1;
      tx_payload_tready = tready_mode ? ~tx_payload_tready : 1'b1;
   end

   // Sample on the falling edge: a handshake seen here completes at the next rising edge
   always @(negedge sys_clk) begin
      cyc++;
      if (system_reset) begin
         if (stall_pending)
            check_eq("stall_hold", {tx_payload_tvalid, tx_payload_tlast, tx_payload_tdata},
                     {1'b1, stall_last, stall_data});
         if (tx_hdr_valid && tx_hdr_ready) begin
            got_hdr.push_back({tx_ip_dest_ip, tx_source_port, tx_dest_port, tx_length});
            hdr_cyc = cyc;
            first_pending = 1;
         end
         if (tx_payload_tvalid && tx_payload_tready) begin
            got_beat.push_back({tx_payload_tlast, tx_payload_tdata});
            if (first_pending) begin
               got_lat.push_back(cyc - hdr_cyc);
               first_pending = 0;
            end
         end
         stall_pending = tx_payload_tvalid && !tx_payload_tready;
         stall_data = tx_payload_tdata;
         stall_last = tx_payload_tlast;
      end else begin
         stall_pending = 0;
      end
   end

   task automatic send_hdr(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                           input logic [15:0] len);
      int t = 0;
      @(negedge sys_clk);
      rx_ip_source_ip = ip; rx_source_port = sp; rx_dest_port = dp; rx_length = len;
      rx_hdr_valid = 1'b1;
      while (!rx_hdr_ready && t < 5000) begin
         @(negedge sys_clk);
         t++;
      end
      if (!rx_hdr_ready) check_eq("hdr_accept_timeout", 0, 1);
      @(posedge sys_clk);
      #1 rx_hdr_valid = 1'b0;
   endtask

   task automatic send_payload(input bit err, input bit with_last);
      for (int i = 0; i < pl.size(); i++) begin
         int t = 0;
         @(negedge sys_clk);
         rx_payload_tvalid = 1'b1;
         rx_payload_tdata  = pl[i];
         rx_payload_tlast  = with_last && (i == pl.size() - 1);
         rx_payload_tuser  = err && rx_payload_tlast;
         while (!rx_payload_tready && t < 100) begin
            @(negedge sys_clk);
            t++;
         end
         if (!rx_payload_tready) check_eq("payload_ready_timeout", 0, 1);
         @(posedge sys_clk);
      end
      #1;
      rx_payload_tvalid = 1'b0; rx_payload_tlast = 1'b0; rx_payload_tuser = 1'b0;
   endtask

   task automatic wait_reply(input int nh, input int nb);
      int t = 0;
      while ((got_hdr.size() < nh || got_beat.size() < nb) && t < 5000) begin
         @(negedge sys_clk);
         t++;
      end
      if (got_hdr.size() < nh || got_beat.size() < nb) check_eq("reply_timeout", 0, 1);
   endtask

   task automatic check_reply(input string tag, input logic [31:0] ip, input logic [15:0] sp,
                              input logic [15:0] dp, input logic [15:0] len);
      logic [79:0] h;
      logic [8:0]  b;
      logic        last_exp;
      if (got_hdr.size() == 0) begin
         check_eq({tag, "_hdr_missing"}, 0, 1);
         return;
      end
      h = got_hdr.pop_front();
      check_eq({tag, "_hdr"}, h, {ip, sp, dp, len});
      for (int i = 0; i < pl.size(); i++) begin
         if (got_beat.size() == 0) begin
            check_eq({tag, "_beat_missing"}, 0, 1);
            return;
         end
         b = got_beat.pop_front();
         last_exp = (i == pl.size() - 1);
         check_eq($sformatf("%s_b%0d", tag, i), b, {last_exp, pl[i]});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      system_reset = 1'b0;
      rx_hdr_valid = 1'b0; rx_ip_source_ip = '0; rx_source_port = '0;
      rx_dest_port = '0; rx_length = '0;
      rx_payload_tvalid = 1'b0; rx_payload_tdata = '0;
      rx_payload_tlast = 1'b0; rx_payload_tuser = 1'b0;
      tx_hdr_ready = 1'b1;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check_eq("rst_rx_hdr_ready", rx_hdr_ready, 0);
      check_eq("rst_rx_tready", rx_payload_tready, 0);
      check_eq("rst_tx_hdr_valid", tx_hdr_valid, 0);
      check_eq("rst_tx_tvalid", tx_payload_tvalid, 0);
      check_eq("rst_tx_tlast", tx_payload_tlast, 0);
      check_eq("rst_drop", drop_count, 0);
      check_eq("rst_busy", busy, 0);
      @(posedge sys_clk);
      #1 system_reset = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_eq("ready_after_release", rx_hdr_ready, 1);

      pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_hdr(32'h0A000002, 16'd1234, 16'd5000, 16'd12);
      send_payload(0, 1);
      wait_reply(1, 4);
      check_eq("echo_hdr_to_data", (got_lat.size() > 0) ? got_lat[0] : 999, 2);
      check_eq("echo_tuser", tx_payload_tuser, 0);
      check_reply("echo", 32'h0A000002, 16'd5000, 16'd1234, 16'd12);
      check_eq("echo_drop", drop_count, 0);

      pl = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
      send_hdr(32'h0A000003, 16'd2000, 16'd5000, 16'd14);
      send_payload(1, 1);
      repeat (10) @(negedge sys_clk);
      check_eq("err_no_reply", got_hdr.size(), 0);
      check_eq("err_drop", drop_count, 1);
      pl = '{8'h01, 8'h02, 8'h03};
      send_hdr(32'hC0A80101, 16'd4000, 16'd5000, 16'd11);
      send_payload(0, 1);
      wait_reply(1, 3);
      check_reply("rewind", 32'hC0A80101, 16'd5000, 16'd4000, 16'd11);

      pl.delete();
      for (int i = 0; i < 1473; i++) pl.push_back(8'(i));
      send_hdr(32'h0A000004, 16'd3000, 16'd5000, 16'd1481);
      send_payload(0, 1);
      repeat (10) @(negedge sys_clk);
      check_eq("oversize_no_reply", got_hdr.size(), 0);
      check_eq("oversize_drop", drop_count, 2);
      check_eq("oversize_ready", rx_hdr_ready, 1);

      pl.delete();
      for (int i = 0; i < 1472; i++) pl.push_back(8'(i * 7 + 3));
      send_hdr(32'h0A000005, 16'd3001, 16'd5000, 16'd1480);
      send_payload(0, 1);
      wait_reply(1, 1472);
      check_reply("max_len", 32'h0A000005, 16'd5000, 16'd3001, 16'd1480);

      send_hdr(32'h0A000006, 16'd3002, 16'd5000, 16'd8);
      repeat (3) @(negedge sys_clk);
      check_eq("zero_len_drop", drop_count, 3);
      check_eq("zero_len_no_payload", rx_payload_tready, 0);
      check_eq("zero_len_no_reply", got_hdr.size(), 0);

      pl = '{8'h77, 8'h88, 8'h99};
      send_hdr(32'h0A000007, 16'd6000, 16'd5001, 16'd11);
      send_payload(0, 1);
      repeat (10) @(negedge sys_clk);
      check_eq("filter_no_reply", got_hdr.size(), 0);
      check_eq("filter_drop", drop_count, 3);
      check_eq("filter_ready", rx_hdr_ready, 1);
      send_hdr(32'h0A000007, 16'd6000, 16'd5000, 16'd11);
      send_payload(0, 1);
      wait_reply(1, 3);
      check_reply("filter_pass", 32'h0A000007, 16'd5000, 16'd6000, 16'd11);

      tx_hdr_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pl = '{8'(16 * k + 1), 8'(16 * k + 2)};
         send_hdr(32'h0A000010 + k, 16'(100 + k), 16'd5000, 16'd10);
         send_payload(0, 1);
      end
      repeat (4) @(negedge sys_clk);
      check_eq("bp_hdr_ready_low", rx_hdr_ready, 0);
      check_eq("bp_busy", busy, 1);
      tready_mode = 1;
      pl = '{8'h41, 8'h42};
      fork
         begin
            send_hdr(32'h0A000014, 16'd104, 16'd5000, 16'd10);
            send_payload(0, 1);
         end
         begin
            repeat (20) @(posedge sys_clk);
            #1 tx_hdr_ready = 1'b1;
         end
      join
      wait_reply(5, 10);
      for (int k = 0; k < 5; k++) begin
         pl = '{8'(16 * k + 1), 8'(16 * k + 2)};
         check_reply($sformatf("bp%0d", k), 32'h0A000010 + k, 16'd5000, 16'(100 + k), 16'd10);
      end

      pl.delete();
      for (int i = 0; i < 30; i++) pl.push_back(8'(8'hA0 + i));
      send_hdr(32'h0A000020, 16'd7000, 16'd5000, 16'd38);
      send_payload(0, 1);
      pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      send_hdr(32'h0A000021, 16'd7001, 16'd5000, 16'd28);
      send_payload(0, 0);
      check_eq("pre_rst_busy", busy, 1);
      system_reset = 1'b0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      check_eq("midrst_rx_hdr_ready", rx_hdr_ready, 0);
      check_eq("midrst_rx_tready", rx_payload_tready, 0);
      check_eq("midrst_tx_hdr_valid", tx_hdr_valid, 0);
      check_eq("midrst_tx_tvalid", tx_payload_tvalid, 0);
      check_eq("midrst_tx_tlast", tx_payload_tlast, 0);
      check_eq("midrst_drop", drop_count, 0);
      check_eq("midrst_busy", busy, 0);
      @(posedge sys_clk);
      #1 system_reset = 1'b1;
      got_hdr.delete();
      got_beat.delete();
      got_lat.delete();
      tready_mode = 0;
      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_hdr(32'h0A000030, 16'd8000, 16'd5000, 16'd12);
      send_payload(0, 1);
      wait_reply(1, 4);
      check_reply("post_rst", 32'h0A000030, 16'd5000, 16'd8000, 16'd12);
      check_eq("post_rst_drop", drop_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
